// File: rtl/tinker_fetch_unit_if.sv
// Fetch unit bus: instruction-memory request/response, redirect/halt control and decode handoff.
// master = fetch unit side, slave = memory/execute/decode side.
interface tinker_fetch_unit_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_resp_valid;
    logic [31:0] imem_resp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt_req;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [63:0] out_pc;
    logic        fetch_halted;

    modport master (
        output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fetch_halted,
        input  imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               halt_req, out_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc, fetch_halted,
        output imem_req_ready, imem_resp_valid, imem_resp_data, redirect_valid, redirect_pc,
               halt_req, out_ready
    );
endinterface

// File: rtl/tinker_fetch_unit.sv
// Instruction-fetch front end: issues fetches, queues returned words with their PCs, handles redirects.
// Optional macro FETCH_HALT_DETECT_EN stops issue after a fetched halt word until the next redirect.
module tinker_fetch_unit #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [63:0] RESET_PC = 64'h2000
) (
    input logic                 clk,
    input logic                 reset,
    tinker_fetch_unit_if.master bus
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [63:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] outstanding_q, outstanding_d;
    logic [CNT_W-1:0] discard_q, discard_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, wr_ptr_q, pcq_rd_q, pcq_wr_q;
    logic [31:0]      instr_q [DEPTH];
    logic [63:0]      ipc_q   [DEPTH];
    logic [63:0]      pcq_q   [DEPTH];
    logic             out_valid_q;
    logic             stop_q;
    logic             resp_s, drop_s, push_s, pop_s, room_s, req_valid_s, req_fire_s;

    assign resp_s      = bus.imem_resp_valid;
    assign drop_s      = resp_s && (discard_q != {CNT_W{1'b0}});
    assign push_s      = resp_s && !drop_s && !bus.redirect_valid;
    assign pop_s       = out_valid_q && bus.out_ready;
    // Queue slots are reserved at issue time, so the queue can never overflow.
    assign room_s      = ({1'b0, count_q} + {1'b0, outstanding_q}) < (CNT_W + 1)'(DEPTH);
    assign req_valid_s = !reset && (state_q == ST_RUN) && !bus.halt_req && !bus.redirect_valid
                         && !stop_q && room_s;
    assign req_fire_s  = req_valid_s && bus.imem_req_ready;

    assign bus.imem_req_valid = req_valid_s;
    assign bus.imem_req_addr  = fetch_pc_q;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_instr      = instr_q[rd_ptr_q];
    assign bus.out_pc         = ipc_q[rd_ptr_q];
    assign bus.fetch_halted   = (state_q == ST_HALTED);

    // Next-state for PC, counters and run/halt state; redirect overrides everything else
    always_comb begin
        outstanding_d = outstanding_q + CNT_W'(req_fire_s) - CNT_W'(resp_s);
        fetch_pc_d    = fetch_pc_q;
        discard_d     = discard_q;
        count_d       = count_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = bus.redirect_pc;
            discard_d  = outstanding_q - CNT_W'(resp_s);
            count_d    = {CNT_W{1'b0}};
        end else begin
            if (req_fire_s) begin
                fetch_pc_d = fetch_pc_q + 64'd4;
            end else begin
                fetch_pc_d = fetch_pc_q;
            end
            if (drop_s) begin
                discard_d = discard_q - CNT_W'(1'b1);
            end else begin
                discard_d = discard_q;
            end
            count_d = count_q + CNT_W'(push_s) - CNT_W'(pop_s);
        end
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (bus.halt_req && (outstanding_q == {CNT_W{1'b0}})) begin
                    state_d = ST_HALTED;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_HALTED: begin
                if (!bus.halt_req) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_HALTED;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // State registers, the in-flight PC queue and the prefetch queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= ST_RUN;
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= {CNT_W{1'b0}};
            discard_q     <= {CNT_W{1'b0}};
            count_q       <= {CNT_W{1'b0}};
            out_valid_q   <= 1'b0;
            rd_ptr_q      <= {PTR_W{1'b0}};
            wr_ptr_q      <= {PTR_W{1'b0}};
            pcq_rd_q      <= {PTR_W{1'b0}};
            pcq_wr_q      <= {PTR_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= 32'h0;
                ipc_q[i]   <= 64'h0;
                pcq_q[i]   <= 64'h0;
            end
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            count_q       <= count_d;
            out_valid_q   <= (count_d != {CNT_W{1'b0}});
            if (req_fire_s) begin
                pcq_q[pcq_wr_q] <= fetch_pc_q;
                pcq_wr_q        <= pcq_wr_q + PTR_W'(1'b1);
            end
            // Every response, kept or dropped, retires its PC entry so pairing stays aligned.
            if (resp_s) begin
                pcq_rd_q <= pcq_rd_q + PTR_W'(1'b1);
            end
            if (bus.redirect_valid) begin
                rd_ptr_q <= {PTR_W{1'b0}};
                wr_ptr_q <= {PTR_W{1'b0}};
            end else begin
                if (push_s) begin
                    instr_q[wr_ptr_q] <= bus.imem_resp_data;
                    ipc_q[wr_ptr_q]   <= pcq_q[pcq_rd_q];
                    wr_ptr_q          <= wr_ptr_q + PTR_W'(1'b1);
                end
                if (pop_s) begin
                    rd_ptr_q <= rd_ptr_q + PTR_W'(1'b1);
                end
            end
        end
    end

`ifdef FETCH_HALT_DETECT_EN
    function automatic logic is_halt_word(input logic [31:0] w);
        return (w[31:27] == 5'h0f) && (w[3:0] == 4'h0);
    endfunction

    // Latches a fetched halt word and blocks issue until the next redirect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stop_q <= 1'b0;
        end else if (bus.redirect_valid) begin
            stop_q <= 1'b0;
        end else if (push_s && is_halt_word(bus.imem_resp_data)) begin
            stop_q <= 1'b1;
        end else begin
            stop_q <= stop_q;
        end
    end
`else
    assign stop_q = 1'b0;
`endif
endmodule

// File: tb/tb_tinker_fetch_unit.sv
// Directed bench for tinker_fetch_unit with an in-order fixed-latency memory model.
module tb_tinker_fetch_unit;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    tinker_fetch_unit_if bus();
    tinker_fetch_unit #(.DEPTH(4), .RESET_PC(64'h2000)) dut (.clk(clk), .reset(reset), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    logic [63:0] mem_addr_q[$];
    int          mem_due_q[$];
    logic [63:0] req_log[$];
    logic [63:0] out_pc_log[$];
    logic [31:0] out_instr_log[$];
    int          out_cyc_log[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
`ifdef FETCH_HALT_DETECT_EN
        if (a == 64'h2008) return 32'h7800_0000;
`endif
        return {a[15:0], 16'h1235};
    endfunction

    // Memory response driver: one response per cycle, in request order
    always @(posedge clk) begin
        cyc = cyc + 1;
        #1;
        if (!reset && mem_due_q.size() > 0 && mem_due_q[0] == cyc) begin
            bus.imem_resp_valid = 1'b1;
            bus.imem_resp_data  = mem_word(mem_addr_q[0]);
            void'(mem_due_q.pop_front());
            void'(mem_addr_q.pop_front());
        end else begin
            bus.imem_resp_valid = 1'b0;
            bus.imem_resp_data  = 32'h0;
        end
    end

    // Handshake monitor: records accepted requests and delivered instructions
    always @(negedge clk) begin
        if (reset) begin
            mem_addr_q.delete();
            mem_due_q.delete();
        end else begin
            if (bus.imem_req_valid && bus.imem_req_ready) begin
                req_log.push_back(bus.imem_req_addr);
                mem_addr_q.push_back(bus.imem_req_addr);
                mem_due_q.push_back(cyc + mem_lat);
            end
            if (bus.out_valid && bus.out_ready) begin
                out_pc_log.push_back(bus.out_pc);
                out_instr_log.push_back(bus.out_instr);
                out_cyc_log.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.halt_req = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        req_log.delete();
        out_pc_log.delete();
        out_instr_log.delete();
        out_cyc_log.delete();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #3;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %0h expected 0", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 64'h2000) begin errors++; $display("FAIL reset_req_addr: got %0h expected 2000", bus.imem_req_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0) begin errors++; $display("FAIL reset_out_instr: got %0h expected 0", bus.out_instr); end
        checks++; if (bus.out_pc !== 64'h0) begin errors++; $display("FAIL reset_out_pc: got %0h expected 0", bus.out_pc); end
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0h expected 0", bus.fetch_halted); end
    endtask

    task automatic test_stream();
        mem_lat = 1;
        apply_reset();
        repeat (14) tick();
        checks++; if (req_log.size() < 8 || out_pc_log.size() < 8) begin errors++; $display("FAIL stream_count: got %0d/%0d expected >=8", req_log.size(), out_pc_log.size()); end
        for (int i = 0; i < 8; i++) begin
            if (i < req_log.size()) begin
                checks++; if (req_log[i] !== 64'h2000 + 64'(4 * i)) begin errors++; $display("FAIL stream_req_addr[%0d]: got %0h expected %0h", i, req_log[i], 64'h2000 + 64'(4 * i)); end
            end
            if (i < out_pc_log.size()) begin
                checks++; if (out_pc_log[i] !== 64'h2000 + 64'(4 * i)) begin errors++; $display("FAIL stream_out_pc[%0d]: got %0h expected %0h", i, out_pc_log[i], 64'h2000 + 64'(4 * i)); end
                checks++; if (out_instr_log[i] !== mem_word(64'h2000 + 64'(4 * i))) begin errors++; $display("FAIL stream_out_instr[%0d]: got %0h expected %0h", i, out_instr_log[i], mem_word(64'h2000 + 64'(4 * i))); end
                checks++; if (out_cyc_log[i] !== out_cyc_log[0] + i) begin errors++; $display("FAIL stream_throughput[%0d]: got cycle %0d expected %0d", i, out_cyc_log[i], out_cyc_log[0] + i); end
            end
        end
    endtask

    task automatic test_backpressure();
        mem_lat = 1;
        apply_reset();
        bus.out_ready = 1'b0;
        repeat (12) tick();
        checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL bp_req_count: got %0d expected 4", req_log.size()); end
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %0h expected 0", bus.imem_req_valid); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h2000) begin errors++; $display("FAIL bp_head: got valid %0h pc %0h expected 1 2000", bus.out_valid, bus.out_pc); end
        bus.out_ready = 1'b1;
        repeat (8) tick();
        checks++; if (req_log.size() < 5 || req_log[4] !== 64'h2010) begin errors++; $display("FAIL bp_resume_addr: got %0h expected 2010", (req_log.size() > 4) ? req_log[4] : 64'h0); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (i >= out_pc_log.size() || out_pc_log[i] !== 64'h2000 + 64'(4 * i)) begin errors++; $display("FAIL bp_out_pc[%0d]: got %0h expected %0h", i, (i < out_pc_log.size()) ? out_pc_log[i] : 64'h0, 64'h2000 + 64'(4 * i)); end
        end
    endtask

    task automatic test_redirect_stale();
        mem_lat = 3;
        apply_reset();
        repeat (3) tick();
        checks++; if (req_log.size() !== 3 || bus.imem_resp_valid !== 1'b1) begin errors++; $display("FAIL stale_setup: got %0d reqs resp %0h expected 3 1", req_log.size(), bus.imem_resp_valid); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h3000;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (20) tick();
        checks++; if (req_log.size() < 4 || req_log[3] !== 64'h3000) begin errors++; $display("FAIL stale_req_after: got %0h expected 3000", (req_log.size() > 3) ? req_log[3] : 64'h0); end
        checks++; if (out_pc_log.size() < 4) begin errors++; $display("FAIL stale_out_count: got %0d expected >=4", out_pc_log.size()); end
        for (int i = 0; i < out_pc_log.size(); i++) begin
            checks++; if (out_pc_log[i] !== 64'h3000 + 64'(4 * i)) begin errors++; $display("FAIL stale_out_pc[%0d]: got %0h expected %0h", i, out_pc_log[i], 64'h3000 + 64'(4 * i)); end
        end
    endtask

    task automatic test_redirect_pop_resp();
        mem_lat = 1;
        apply_reset();
        repeat (6) tick();
        checks++; if (bus.imem_resp_valid !== 1'b1 || bus.out_valid !== 1'b1) begin errors++; $display("FAIL rpr_setup: got resp %0h valid %0h expected 1 1", bus.imem_resp_valid, bus.out_valid); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h4000;
        tick();
        bus.redirect_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rpr_empty_next: got %0h expected 0", bus.out_valid); end
        checks++; if (out_pc_log.size() !== 5 || out_pc_log[4] !== 64'h2010) begin errors++; $display("FAIL rpr_popped: got %0d entries expected 5 ending 2010", out_pc_log.size()); end
        repeat (5) tick();
        checks++; if (out_pc_log.size() < 6 || out_pc_log[5] !== 64'h4000) begin errors++; $display("FAIL rpr_next_pc: got %0h expected 4000", (out_pc_log.size() > 5) ? out_pc_log[5] : 64'h0); end
    endtask

    task automatic test_halt();
        mem_lat = 3;
        apply_reset();
        tick();
        tick();
        bus.halt_req = 1'b1;
        #1;
        checks++; if (req_log.size() !== 2 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL halt_block: got %0d reqs valid %0h expected 2 0", req_log.size(), bus.imem_req_valid); end
        tick();
        tick();
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL halt_early: got %0h expected 0", bus.fetch_halted); end
        repeat (4) tick();
        checks++; if (bus.fetch_halted !== 1'b1) begin errors++; $display("FAIL halt_entered: got %0h expected 1", bus.fetch_halted); end
        checks++; if (req_log.size() !== 2) begin errors++; $display("FAIL halt_req_count: got %0d expected 2", req_log.size()); end
        checks++; if (out_pc_log.size() !== 2 || out_pc_log[1] !== 64'h2004 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL halt_drain: got %0d entries valid %0h expected 2 0", out_pc_log.size(), bus.out_valid); end
        bus.halt_req = 1'b0;
        repeat (8) tick();
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL halt_exit: got %0h expected 0", bus.fetch_halted); end
        checks++; if (req_log.size() < 3 || req_log[2] !== 64'h2008) begin errors++; $display("FAIL halt_resume_addr: got %0h expected 2008", (req_log.size() > 2) ? req_log[2] : 64'h0); end
    endtask

    task automatic test_async_reset();
        mem_lat = 3;
        apply_reset();
        bus.out_ready = 1'b0;
        repeat (5) tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.imem_req_addr !== 64'h2010) begin errors++; $display("FAIL areset_setup: got valid %0h addr %0h expected 1 2010", bus.out_valid, bus.imem_req_addr); end
        #1;
        reset = 1'b1;
        #1;
        checks++; if (bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL areset_req_valid: got %0h expected 0", bus.imem_req_valid); end
        checks++; if (bus.imem_req_addr !== 64'h2000) begin errors++; $display("FAIL areset_req_addr: got %0h expected 2000", bus.imem_req_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL areset_out_valid: got %0h expected 0", bus.out_valid); end
        checks++; if (bus.out_instr !== 32'h0 || bus.out_pc !== 64'h0) begin errors++; $display("FAIL areset_out_data: got %0h %0h expected 0 0", bus.out_instr, bus.out_pc); end
        checks++; if (bus.fetch_halted !== 1'b0) begin errors++; $display("FAIL areset_halted: got %0h expected 0", bus.fetch_halted); end
    endtask

`ifdef FETCH_HALT_DETECT_EN
    task automatic test_halt_detect();
        mem_lat = 1;
        apply_reset();
        repeat (10) tick();
        checks++; if (req_log.size() !== 4 || bus.imem_req_valid !== 1'b0) begin errors++; $display("FAIL hd_stop: got %0d reqs valid %0h expected 4 0", req_log.size(), bus.imem_req_valid); end
        checks++; if (out_pc_log.size() < 3 || out_pc_log[2] !== 64'h2008 || out_instr_log[2] !== 32'h7800_0000) begin errors++; $display("FAIL hd_word: got %0d entries expected word 78000000 at 2008", out_pc_log.size()); end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = 64'h2000;
        tick();
        bus.redirect_valid = 1'b0;
        repeat (3) tick();
        checks++; if (req_log.size() < 5 || req_log[4] !== 64'h2000) begin errors++; $display("FAIL hd_restart: got %0h expected 2000", (req_log.size() > 4) ? req_log[4] : 64'h0); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        bus.imem_req_ready = 1'b1;
        bus.imem_resp_valid = 1'b0;
        bus.imem_resp_data = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = 64'h0;
        bus.halt_req = 1'b0;
        bus.out_ready = 1'b1;
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_stale();
        test_redirect_pop_resp();
        test_halt();
        test_async_reset();
`ifdef FETCH_HALT_DETECT_EN
        test_halt_detect();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/tinker_fetch_unit.md
Name: tinker_fetch_unit

Overview:
- Instruction-fetch front end; sits directly upstream of the Tinker decode/execute core.
- Issues 32-bit instruction-fetch requests to the instruction memory port and buffers returned instructions in a DEPTH-entry prefetch queue.
- Hands instructions and their PCs to decode over a valid/ready handshake.
- Accepts PC redirects from execute (jump, branch, call, return): flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, prefetch queue entries and maximum outstanding requests (power of 2, at least 2)
RESET_PC, 64'h2000, fetch PC after reset

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request this cycle
imem_req_addr  output  64  byte address of request (the current fetch PC)
imem_resp_valid  input  1  response valid; responses return in request order, at least 1 cycle after acceptance
imem_resp_data  input  32  little-endian instruction word
redirect_valid  input  1  one-cycle PC redirect strobe
redirect_pc  input  64  new fetch PC
halt_req  input  1  level; stop issuing new requests
out_valid  output  1  queue head valid
out_ready  input  1  decode accepts head
out_instr  output  32  head instruction
out_pc  output  64  PC of head instruction
fetch_halted  output  1  no requests will issue (halted state)

Behaviour:
- Reset values:
  - imem_req_valid=0, imem_req_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_halted=0.
  - Queue empty; outstanding=0; discard=0; state=RUN.
- Clocking: all state updates on the rising edge of clk. Reset clears all state asynchronously, including mid-request; responses arriving after reset deasserts are not discarded (the memory side resets together with this block).
- Counters:
  - outstanding (clog2(DEPTH+1) bits) counts accepted requests without a response.
  - discard counts responses to drop.
- Issue rule:
  - imem_req_valid = (state==RUN) && !halt_req && !redirect_valid && (occupancy + outstanding < DEPTH).
  - On req handshake: outstanding+1, fetch PC += 4.
  - The PC wraps modulo 2^64.
- Response handling:
  - If discard>0: response dropped, discard-1, outstanding-1.
  - Otherwise the response is pushed with its PC (a pc queue, pushed at request time, pairs each response with its PC) and outstanding-1.
  - The queue never overflows, by the issue rule.
- Output:
  - out_valid = queue not empty; out_instr and out_pc come from the head register.
  - Pop on out_valid && out_ready.
  - Push and pop in the same cycle at full or empty: both occur and occupancy is unchanged.
  - Empty queue with a same-cycle response: out_valid asserts on the next cycle. There is no bypass; the latency from response to out_valid is 1 cycle.
- Redirect (priority over every other event in its cycle):
  - A pop in the same cycle completes: decode consumed that instruction.
  - All other queue entries are flushed.
  - discard <= outstanding minus (1 if a response arrives this cycle and discard==0 then, else 0), plus the existing discard adjusted likewise. Net: every request still in flight after the edge is discarded.
  - Fetch PC <= redirect_pc.
  - The state moves from HALTED to RUN only if halt_req==0.
  - redirect_pc[1:0] != 0 is allowed; the address is passed through unaligned.
- States:
  - RUN: issue per the rule above.
  - HALTED: entered when halt_req==1 and outstanding==0. fetch_halted=1, no issue; the queue still drains to decode and responses are still accepted.
  - HALTED → RUN on halt_req==0.
  - Asserting halt_req in RUN blocks issue immediately.

Optional Feature:
- Macro FETCH_HALT_DETECT_EN.
- Defined:
  - When a non-discarded response has instr[31:27]==5'h0f and instr[3:0]==0, it is enqueued normally.
  - Issue then stops, as if halt_req were held, until the next redirect or reset.
  - Subsequent in-flight responses are pushed normally.
- Undefined: no decoding; only halt_req stops fetch.

Test Plan:
- Reset, memory with 1-cycle latency, out_ready=1 → first req addr 0x2000, then 0x2004, 0x2008…; out_pc sequence matches, with a sustained throughput of 1 instruction/cycle.
- out_ready=0 with DEPTH=4 → exactly 4 requests accepted, imem_req_valid=0 after that; release out_ready → fetch resumes at 0x2010.
- Memory latency 3 cycles with 3 requests in flight, then redirect_valid with redirect_pc=0x3000 → the 3 stale responses are dropped, the next out_pc=0x3000, and no 0x200x PC appears after the redirect.
- Redirect in the same cycle as a pop and a response arrival → the popped instruction counts, the response is dropped, and the queue is empty next cycle.
- halt_req=1 with 2 outstanding → no new request; fetch_halted rises once both responses return; the queue drains; halt_req=0 → issue resumes at the next sequential PC.
- FETCH_HALT_DETECT_EN defined, word 0x78000000 at 0x2008 → that word is delivered with out_pc=0x2008, no request beyond the already in-flight ones, and redirect to 0x2000 restarts fetch.
- Reset asserted with 2 requests outstanding → all outputs return to their reset values immediately, without waiting for a clock edge.
